// File: rtl/reset_sequencer.sv
// reset_sequencer: synchronises the release of an asynchronous active-low
// reset and then releases N_OUT synchronous active-low reset outputs one at a
// time, HOLD_CYCLES clk cycles apart, channel 0 first.
//
// Optional feature: define RESET_SEQ_SWRST_EN to let sw_rst_req, sampled high
// once the sequence has completed, restart the whole sequence. Without the
// macro the port is present but ignored, and completion is terminal until
// rst_n asserts again.
module reset_sequencer #(
  parameter int SYNC_STAGES = 2,
  parameter int N_OUT       = 4,
  parameter int HOLD_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sw_rst_req,
  output logic [N_OUT-1:0] srst_n,
  output logic             rst_done,
  output logic             busy
);

  // Parameter sanity: refuse to elaborate configurations that make no sense.
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("reset_sequencer: SYNC_STAGES must be >= 2");
  end
  if (N_OUT < 1) begin : g_bad_nout
    $error("reset_sequencer: N_OUT must be >= 1");
  end
  if (HOLD_CYCLES < 1) begin : g_bad_hold
    $error("reset_sequencer: HOLD_CYCLES must be >= 1");
  end

  localparam int CW = $clog2(HOLD_CYCLES + 1);
  localparam int IW = (N_OUT > 1) ? $clog2(N_OUT) : 1;

  localparam logic [CW-1:0] CNT_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(N_OUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Reset-release synchroniser chain: cleared asynchronously, shifts in 1.
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_n;
  logic                   sync_rising;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q,   cnt_d;
  logic [IW-1:0]    idx_q,   idx_d;
  logic [N_OUT-1:0] srst_q,  srst_d;
  logic             done_q,  done_d;
  logic             sw_restart;

  assign sync_n      = sync_q[SYNC_STAGES-1];
  // The IDLE->SEQ transition happens on the very edge at which sync_n goes
  // high, so that edge becomes sequence edge 0; the stage feeding the last
  // flop tells us this edge is that one.
  assign sync_rising = sync_q[SYNC_STAGES-2];

`ifdef RESET_SEQ_SWRST_EN
  assign sw_restart = sw_rst_req;
`else
  logic unused_sw_rst_req;
  assign unused_sw_rst_req = sw_rst_req;
  assign sw_restart        = 1'b0;
`endif

  // Synchroniser chain: asynchronous clear, synchronous release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  // FSM, counters and output registers; any rst_n pulse aborts the sequence.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      srst_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      srst_q  <= srst_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic: count HOLD_CYCLES per channel, release channels in order.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    srst_d  = srst_q;
    done_d  = done_q;

    unique case (state_q)
      IDLE: begin
        if (sync_rising || sync_n) begin
          state_d = SEQ;
          cnt_d   = '0;
          idx_d   = '0;
        end
      end

      SEQ: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d         = '0;
          srst_d[idx_q] = 1'b1;
          if (idx_q == IDX_LAST) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      DONE: begin
        if (sw_restart) begin
          state_d = SEQ;
          cnt_d   = '0;
          idx_d   = '0;
          srst_d  = '0;
          done_d  = 1'b0;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        idx_d   = '0;
        srst_d  = '0;
        done_d  = 1'b0;
      end
    endcase
  end

  // busy is decoded from registered state, so it only changes on clk edges
  // or goes low on an asynchronous reset.
  always_comb begin
    busy = 1'b0;
    if (state_q == SEQ) begin
      busy = 1'b1;
    end else if (state_q == IDLE && sync_n) begin
      busy = 1'b1;
    end
  end

  assign srst_n   = srst_q;
  assign rst_done = done_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer (SYNC_STAGES=2, N_OUT=4, HOLD_CYCLES=3)
// plus a HOLD_CYCLES=1, N_OUT=2 instance. Edge numbering: edge 1 is the first
// clk rising edge after rst_n deasserts.
module tb_reset_sequencer;

  logic       clk;
  logic       rst_n;
  logic       sw_rst_req;
  logic [3:0] srst_n;
  logic       rst_done;
  logic       busy;
  logic [1:0] h1_srst_n;
  logic       h1_rst_done;
  logic       h1_busy;

  int vecs  = 0;
  int fails = 0;
  int ecnt  = 0;

  typedef struct {
    int         cyc;
    logic       sw;
    logic [3:0] srst;
    logic       done;
    logic       busy;
  } vec_t;

  vec_t tbl[$];

  reset_sequencer #(.SYNC_STAGES(2), .N_OUT(4), .HOLD_CYCLES(3)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sw_rst_req(sw_rst_req),
    .srst_n    (srst_n),
    .rst_done  (rst_done),
    .busy      (busy)
  );

  reset_sequencer #(.SYNC_STAGES(2), .N_OUT(2), .HOLD_CYCLES(1)) u_h1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .sw_rst_req(1'b0),
    .srst_n    (h1_srst_n),
    .rst_done  (h1_rst_done),
    .busy      (h1_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    vecs++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @edge %0d: got %b, expected %b", name, ecnt, act, exp);
    end
  endtask

  task automatic check_main(input string tag, input logic [3:0] s, input logic d, input logic b);
    check({tag, ".srst_n"},   {4'b0, srst_n},   {4'b0, s});
    check({tag, ".rst_done"}, {7'b0, rst_done}, {7'b0, d});
    check({tag, ".busy"},     {7'b0, busy},     {7'b0, b});
  endtask

  task automatic tick();
    @(posedge clk);
    ecnt++;
    #1;
  endtask

  // Hold rst_n low across at least one edge, then release just before edge 1.
  task automatic restart();
    rst_n = 1'b0;
    @(posedge clk);
    #2;
    check_main("in_reset", 4'b0000, 1'b0, 1'b0);
    check("in_reset.h1_srst_n", {6'b0, h1_srst_n}, 8'h00);
    @(negedge clk);
    ecnt  = 0;
    rst_n = 1'b1;
  endtask

  task automatic add(input int c, input logic w, input logic [3:0] s, input logic d, input logic b);
    vec_t v;
    v.cyc = c; v.sw = w; v.srst = s; v.done = d; v.busy = b;
    tbl.push_back(v);
  endtask

  initial begin
    rst_n      = 1'b0;
    sw_rst_req = 1'b0;

    // Power-up timeline with an ignored request at edge 7 (in SEQ).
    add(1,  1'b0, 4'b0000, 1'b0, 1'b0);
    add(2,  1'b0, 4'b0000, 1'b0, 1'b1);
    add(4,  1'b0, 4'b0000, 1'b0, 1'b1);
    add(5,  1'b0, 4'b0001, 1'b0, 1'b1);
    add(7,  1'b1, 4'b0001, 1'b0, 1'b1);
    add(8,  1'b0, 4'b0011, 1'b0, 1'b1);
    add(10, 1'b0, 4'b0011, 1'b0, 1'b1);
    add(11, 1'b0, 4'b0111, 1'b0, 1'b1);
    add(13, 1'b0, 4'b0111, 1'b0, 1'b1);
    add(14, 1'b0, 4'b1111, 1'b1, 1'b0);
    add(19, 1'b0, 4'b1111, 1'b1, 1'b0);
`ifdef RESET_SEQ_SWRST_EN
    // Software restart pulsed at edge 20.
    add(20, 1'b1, 4'b0000, 1'b0, 1'b1);
    add(22, 1'b0, 4'b0000, 1'b0, 1'b1);
    add(23, 1'b0, 4'b0001, 1'b0, 1'b1);
    add(26, 1'b0, 4'b0011, 1'b0, 1'b1);
    add(29, 1'b0, 4'b0111, 1'b0, 1'b1);
    add(31, 1'b0, 4'b0111, 1'b0, 1'b1);
    add(32, 1'b0, 4'b1111, 1'b1, 1'b0);
    add(34, 1'b0, 4'b1111, 1'b1, 1'b0);
`else
    // Without the feature the request in DONE changes nothing.
    add(20, 1'b1, 4'b1111, 1'b1, 1'b0);
    add(23, 1'b0, 4'b1111, 1'b1, 1'b0);
    add(32, 1'b0, 4'b1111, 1'b1, 1'b0);
`endif

    #2;
    check_main("por", 4'b0000, 1'b0, 1'b0);
    restart();

    foreach (tbl[i]) begin
      while (ecnt < tbl[i].cyc - 1) begin
        sw_rst_req = 1'b0;
        tick();
      end
      sw_rst_req = tbl[i].sw;
      tick();
      sw_rst_req = 1'b0;
      check_main($sformatf("vec%0d", i), tbl[i].srst, tbl[i].done, tbl[i].busy);
    end

    // HOLD_CYCLES=1, N_OUT=2 instance, then a 0.3-cycle rst_n glitch
    // between edges 9 and 10 on the main instance.
    restart();
    tick();
    tick();
    check("h1.e2.srst_n", {6'b0, h1_srst_n}, 8'b0000_0000);
    check("h1.e2.busy",   {7'b0, h1_busy},   8'd1);
    tick();
    check("h1.e3.srst_n", {6'b0, h1_srst_n}, 8'b0000_0001);
    check("h1.e3.done",   {7'b0, h1_rst_done}, 8'd0);
    tick();
    check("h1.e4.srst_n", {6'b0, h1_srst_n}, 8'b0000_0011);
    check("h1.e4.done",   {7'b0, h1_rst_done}, 8'd1);
    check("h1.e4.busy",   {7'b0, h1_busy},   8'd0);

    while (ecnt < 9) tick();
    check_main("abort.e9", 4'b0011, 1'b0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_main("abort.glitch", 4'b0000, 1'b0, 1'b0);
    #2;
    rst_n = 1'b1;
    tick();
    check_main("abort.e10", 4'b0000, 1'b0, 1'b0);
    tick();
    check_main("abort.e11", 4'b0000, 1'b0, 1'b1);
    tick();
    tick();
    check_main("abort.e13", 4'b0000, 1'b0, 1'b1);
    tick();
    check_main("abort.e14", 4'b0001, 1'b0, 1'b1);
    while (ecnt < 23) tick();
    check_main("abort.e23", 4'b1111, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

endmodule
